// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared definitions for the instruction-fetch stage: PC and instruction
// widths, the default reset PC, the fetch FSM state encoding and a small
// PC increment helper.
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam int PC_W    = 30;
    localparam int INSTR_W = 32;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    // Word address [31:2] of the first instruction (byte address 0x0000_3000)
    localparam pc_t RESET_PC_DEFAULT = 30'h00000C00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_SQUASH
    } fetch_state_t;

    // Word-address increment; wraps from 30'h3FFFFFFF to 0
    function automatic pc_t pc_inc(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Bundles the signals the fetch stage exchanges with its neighbours:
//   redirect_valid/redirect_pc  : redirect from next-PC select
//   pc_cur                      : current fetch PC back to next-PC select
//   imem_req/addr/ack/rdata     : instruction-memory request/response
//   id_valid/instr/pc/ready     : valid/ready handshake to decode
// Modports: master = fetch unit, slave = surrounding pipeline/memory.
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic   redirect_valid;
    pc_t    redirect_pc;
    pc_t    pc_cur;
    logic   imem_req;
    pc_t    imem_addr;
    logic   imem_ack;
    instr_t imem_rdata;
    logic   id_valid;
    instr_t id_instr;
    pc_t    id_pc;
    logic   id_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
        output pc_cur, imem_req, imem_addr, id_valid, id_instr, id_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
        input  pc_cur, imem_req, imem_addr, id_valid, id_instr, id_pc
    );

endinterface

// File: rtl/if_out_buf.sv
// ---------------------------------------------------------------------------
// if_out_buf
// Decode-side output buffer of the fetch stage plus one skid register.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   load_new           : write new_instr/new_pc straight into the buffer
//   park               : write new_instr/new_pc into the skid register
//   unpark             : move the skid register into the buffer
//   flush              : drop buffer contents and clear the skid
//   new_instr, new_pc  : freshly fetched word and its PC
//   id_ready           : decode accepts the buffer this cycle
//   id_valid/instr/pc  : buffer contents presented to decode
//   buf_free           : buffer can take a new word at the next edge
// ---------------------------------------------------------------------------
module if_out_buf
    import if_fetch_unit_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_new,
    input  logic   park,
    input  logic   unpark,
    input  logic   flush,
    input  instr_t new_instr,
    input  pc_t    new_pc,
    input  logic   id_ready,
    output logic   id_valid,
    output instr_t id_instr,
    output pc_t    id_pc,
    output logic   buf_free
);

    instr_t skid_instr;
    pc_t    skid_pc;
    logic   transfer;

    assign transfer = id_valid & id_ready;
    assign buf_free = !id_valid | id_ready;

    // Buffer and skid update. Flush wins over everything; a word consumed
    // by decode in the same cycle is simply gone. Occupancy of the skid is
    // tracked by the fetch FSM (S_HOLD), so only its data lives here.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid   <= 1'b0;
            id_instr   <= '0;
            id_pc      <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            id_valid   <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            if (load_new) begin
                id_valid <= 1'b1;
                id_instr <= new_instr;
                id_pc    <= new_pc;
            end else if (unpark) begin
                id_valid <= 1'b1;
                id_instr <= skid_instr;
                id_pc    <= skid_pc;
            end else if (transfer) begin
                id_valid <= 1'b0;
            end
            if (park) begin
                skid_instr <= new_instr;
                skid_pc    <= new_pc;
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: owns the PC register, requests instruction words
// from memory and hands them to decode over a valid/ready handshake.
// Redirects from next-PC select replace the PC and squash wrong-path work.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : if_fetch_unit_if.master (redirect, pc_cur, imem_*, id_*)
//   perf_fetch_cnt, perf_squash_cnt : only when IF_PERF_CNT_EN is defined;
//               count transfers to decode and discarded memory responses
// Parameter:
//   RESET_PC  : word address loaded at reset
// Optional feature macro: IF_PERF_CNT_EN
// ---------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter pc_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    if_fetch_unit_if.master bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_squash_cnt
`endif
);

    fetch_state_t state, state_next;
    pc_t          pc_cur, pc_next;
    pc_t          imem_addr_q;
    logic         load_new, park, unpark, flush;
    logic         buf_free;

    assign bus.pc_cur    = pc_cur;
    assign bus.imem_addr = imem_addr_q;
    // A squashed request must stay asserted until memory answers it
    assign bus.imem_req  = (state == S_REQ) || (state == S_SQUASH);

    // State, PC and request address. The request address is captured only
    // when entering S_REQ so it stays stable while pc_cur moves on a
    // redirect into S_SQUASH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc_cur      <= RESET_PC;
            imem_addr_q <= '0;
        end else begin
            state  <= state_next;
            pc_cur <= pc_next;
            if (state_next == S_REQ) begin
                imem_addr_q <= pc_next;
            end
        end
    end

    // Next-state and buffer control. Redirect overrides PC and flushes the
    // decode side regardless of state. In S_SQUASH an ack always ends the
    // wrong-path request, even alongside a redirect, since no further ack
    // would ever arrive for it.
    always_comb begin
        state_next = state;
        pc_next    = pc_cur;
        load_new   = 1'b0;
        park       = 1'b0;
        unpark     = 1'b0;
        flush      = 1'b0;

        case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                if (bus.redirect_valid) begin
                    state_next = bus.imem_ack ? S_REQ : S_SQUASH;
                end else if (bus.imem_ack) begin
                    pc_next = pc_inc(pc_cur);
                    if (buf_free) begin
                        load_new = 1'b1;
                    end else begin
                        park       = 1'b1;
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid) begin
                    state_next = S_REQ;
                end else if (bus.id_ready) begin
                    unpark     = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_SQUASH: begin
                if (bus.imem_ack) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (bus.redirect_valid) begin
            pc_next = bus.redirect_pc;
            flush   = 1'b1;
        end
    end

    if_out_buf u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load_new  (load_new),
        .park      (park),
        .unpark    (unpark),
        .flush     (flush),
        .new_instr (bus.imem_rdata),
        .new_pc    (pc_cur),
        .id_ready  (bus.id_ready),
        .id_valid  (bus.id_valid),
        .id_instr  (bus.id_instr),
        .id_pc     (bus.id_pc),
        .buf_free  (buf_free)
    );

`ifdef IF_PERF_CNT_EN
    logic drop_ack;

    // An ack is discarded when it coincides with a redirect in S_REQ or
    // when it answers a squashed request
    assign drop_ack = bus.imem_ack &&
                      (((state == S_REQ) && bus.redirect_valid) || (state == S_SQUASH));

    // Free-running wrap-around performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt  <= '0;
            perf_squash_cnt <= '0;
        end else begin
            if (bus.id_valid && bus.id_ready) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (drop_ack) begin
                perf_squash_cnt <= perf_squash_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed testbench for if_fetch_unit. A main instance runs reset,
// streaming, backpressure and both redirect cases; a second instance with
// RESET_PC = 30'h3FFFFFFF covers PC wrap. Words expected at decode are
// queued when the ack is driven and popped on each decode transfer.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } exp_t;

    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;
    exp_t main_q[$];
    exp_t wrap_q[$];

    if_fetch_unit_if bus();
    if_fetch_unit_if wbus();

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_squash_cnt;
    logic [31:0] w_perf_fetch_cnt, w_perf_squash_cnt;
`endif

    if_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_squash_cnt (perf_squash_cnt)
`endif
    );

    if_fetch_unit #(.RESET_PC(30'h3FFFFFFF)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (w_perf_fetch_cnt),
        .perf_squash_cnt (w_perf_squash_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive main-instance inputs, then advance one clock; outputs are
    // settled 1 time unit after the edge when this returns
    task automatic applyStimulus(input logic redir, input pc_t redir_pc,
                                 input logic ack, input instr_t rdata,
                                 input logic ready);
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir_pc;
        bus.imem_ack       = ack;
        bus.imem_rdata     = rdata;
        bus.id_ready       = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic driveWrap(input logic ack, input instr_t rdata);
        wbus.imem_ack   = ack;
        wbus.imem_rdata = rdata;
    endtask

    // Scoreboard for the main instance: every decode transfer pops one entry
    always @(negedge clk) begin
        if (!rst && bus.id_valid && bus.id_ready) begin
            if (main_q.size() == 0) begin
                checkOutput("main_unexpected_xfer_pc", {2'b00, bus.id_pc}, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = main_q.pop_front();
                checkOutput("main_xfer_pc", {2'b00, bus.id_pc}, {2'b00, e.pc});
                checkOutput("main_xfer_instr", bus.id_instr, e.instr);
            end
        end
    end

    // Scoreboard for the wrap instance
    always @(negedge clk) begin
        if (!rst && wbus.id_valid && wbus.id_ready) begin
            if (wrap_q.size() == 0) begin
                checkOutput("wrap_unexpected_xfer_pc", {2'b00, wbus.id_pc}, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = wrap_q.pop_front();
                checkOutput("wrap_xfer_pc", {2'b00, wbus.id_pc}, {2'b00, e.pc});
                checkOutput("wrap_xfer_instr", wbus.id_instr, e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst                 = 1'b1;
        wbus.redirect_valid = 1'b0;
        wbus.redirect_pc    = '0;
        wbus.id_ready       = 1'b1;
        driveWrap(1'b0, '0);

        // Reset held for two edges
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("rst_pc_cur",    {2'b00, bus.pc_cur},    32'h00000C00);
        checkOutput("rst_imem_req",  {31'b0, bus.imem_req},  32'd0);
        checkOutput("rst_imem_addr", {2'b00, bus.imem_addr}, 32'd0);
        checkOutput("rst_id_valid",  {31'b0, bus.id_valid},  32'd0);
        checkOutput("rst_id_instr",  bus.id_instr,           32'd0);
        checkOutput("rst_id_pc",     {2'b00, bus.id_pc},     32'd0);

        // First request one cycle after reset release
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("first_req",      {31'b0, bus.imem_req},  32'd1);
        checkOutput("first_req_addr", {2'b00, bus.imem_addr}, 32'h00000C00);

        // Memory answers one cycle after the request
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("req_stable_addr", {2'b00, bus.imem_addr}, 32'h00000C00);
        checkOutput("no_valid_yet",    {31'b0, bus.id_valid},  32'd0);

        // Streaming, one instruction per ack
        main_q.push_back('{pc: 30'h00000C00, instr: 32'h20080001});
        applyStimulus(1'b0, '0, 1'b1, 32'h20080001, 1'b1);
        checkOutput("stream0_valid", {31'b0, bus.id_valid}, 32'd1);
        checkOutput("stream0_pc",    {2'b00, bus.id_pc},    32'h00000C00);
        checkOutput("stream0_instr", bus.id_instr,          32'h20080001);
        checkOutput("stream0_addr",  {2'b00, bus.imem_addr}, 32'h00000C01);
        main_q.push_back('{pc: 30'h00000C01, instr: 32'h20090002});
        applyStimulus(1'b0, '0, 1'b1, 32'h20090002, 1'b1);
        checkOutput("stream1_pc",    {2'b00, bus.id_pc}, 32'h00000C01);
        checkOutput("stream1_valid", {31'b0, bus.id_valid}, 32'd1);
        main_q.push_back('{pc: 30'h00000C02, instr: 32'h01095020});
        applyStimulus(1'b0, '0, 1'b1, 32'h01095020, 1'b1);
        checkOutput("stream2_pc",    {2'b00, bus.id_pc},  32'h00000C02);
        checkOutput("stream2_pc_cur", {2'b00, bus.pc_cur}, 32'h00000C03);

        // Backpressure: ack lands while decode stalls, word goes to skid
        main_q.push_back('{pc: 30'h00000C03, instr: 32'h8C430004});
        applyStimulus(1'b0, '0, 1'b1, 32'h8C430004, 1'b0);
        checkOutput("hold_req",   {31'b0, bus.imem_req}, 32'd0);
        checkOutput("hold_instr", bus.id_instr,          32'h01095020);
        // Stray ack while holding must be ignored
        applyStimulus(1'b0, '0, 1'b1, 32'hBAD0BAD0, 1'b0);
        checkOutput("hold_stray_req",   {31'b0, bus.imem_req}, 32'd0);
        checkOutput("hold_stray_instr", bus.id_instr,          32'h01095020);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("hold3_pc", {2'b00, bus.id_pc}, 32'h00000C02);
        // Release: skid word moves up, fetch resumes
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("unpark_pc",    {2'b00, bus.id_pc},     32'h00000C03);
        checkOutput("unpark_instr", bus.id_instr,           32'h8C430004);
        checkOutput("resume_req",   {31'b0, bus.imem_req},  32'd1);
        checkOutput("resume_addr",  {2'b00, bus.imem_addr}, 32'h00000C04);

        // Redirect while the request is outstanding
        applyStimulus(1'b1, 30'h00000D00, 1'b0, '0, 1'b1);
        checkOutput("sq_id_valid", {31'b0, bus.id_valid},  32'd0);
        checkOutput("sq_pc_cur",   {2'b00, bus.pc_cur},    32'h00000D00);
        checkOutput("sq_req",      {31'b0, bus.imem_req},  32'd1);
        checkOutput("sq_addr",     {2'b00, bus.imem_addr}, 32'h00000C04);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("sq_wait_valid", {31'b0, bus.id_valid}, 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 32'hDEADBEEF, 1'b1);
        checkOutput("sq_done_valid", {31'b0, bus.id_valid},  32'd0);
        checkOutput("sq_done_addr",  {2'b00, bus.imem_addr}, 32'h00000D00);
        checkOutput("sq_done_req",   {31'b0, bus.imem_req},  32'd1);

        // Redirect coinciding with an ack: the word is dropped
        applyStimulus(1'b1, 30'h00000E10, 1'b1, 32'hCAFEF00D, 1'b1);
        checkOutput("rdack_valid", {31'b0, bus.id_valid},  32'd0);
        checkOutput("rdack_addr",  {2'b00, bus.imem_addr}, 32'h00000E10);
        checkOutput("rdack_pc",    {2'b00, bus.pc_cur},    32'h00000E10);
        main_q.push_back('{pc: 30'h00000E10, instr: 32'h12345678});
        applyStimulus(1'b0, '0, 1'b1, 32'h12345678, 1'b1);
        checkOutput("after_redir_pc",     {2'b00, bus.id_pc},  32'h00000E10);
        checkOutput("after_redir_pc_cur", {2'b00, bus.pc_cur}, 32'h00000E11);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("main_q_drained", 32'(main_q.size()), 32'd0);
`ifdef IF_PERF_CNT_EN
        checkOutput("perf_fetch",  perf_fetch_cnt,  32'd5);
        checkOutput("perf_squash", perf_squash_cnt, 32'd2);
`endif

        // PC wrap on the second instance
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("wrap_rst_pc", {2'b00, wbus.pc_cur}, 32'h3FFFFFFF);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("wrap_first_addr", {2'b00, wbus.imem_addr}, 32'h3FFFFFFF);
        wrap_q.push_back('{pc: 30'h3FFFFFFF, instr: 32'hAAAA0001});
        driveWrap(1'b1, 32'hAAAA0001);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("wrap0_id_pc",  {2'b00, wbus.id_pc},     32'h3FFFFFFF);
        checkOutput("wrap0_pc_cur", {2'b00, wbus.pc_cur},    32'd0);
        checkOutput("wrap0_addr",   {2'b00, wbus.imem_addr}, 32'd0);
        wrap_q.push_back('{pc: 30'h00000000, instr: 32'hAAAA0002});
        driveWrap(1'b1, 32'hAAAA0002);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("wrap1_id_pc",  {2'b00, wbus.id_pc},  32'd0);
        checkOutput("wrap1_pc_cur", {2'b00, wbus.pc_cur}, 32'd1);
        driveWrap(1'b0, '0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("wrap_q_drained", 32'(wrap_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
